ucie_ctl_csr_err_collector: RTL and testbench
=============================================

UCIE_CTL_CSR_ERR_COLLECTOR -- requirements
Module: ucie_ctl_csr_err_collector

Interface
REQ-001 SHALL have parameter COALESCE_CYCLES, default 3: hold-off cycles from first pending event before the first write of a burst; legal range 0..15.
REQ-002 SHALL have port i_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_unc_err, input, 6 bits: single-cycle event pulses for uncorrectable error status (CSR 0x34 bits [5:0]).
REQ-005 SHALL have port i_int_err, input, 8 bits: event pulses for internal error status (CSR 0x24 bits [7:0]); bit 5 is ignored.
REQ-006 SHALL have port i_adp_err, input, 2 bits: event pulses for adapter error status (CSR 0x2C bits [1:0]).
REQ-007 SHALL have port i_link_sts, input, 32 bits: level link-status word for CSR 0x14.
REQ-008 SHALL have port o_A_Valid, output, 1 bit: one-cycle write strobe to the CSR adapter write port.
REQ-009 SHALL have port o_A_addr, output, 8 bits: CSR byte address of the write.
REQ-010 SHALL have port o_A_WDATA, output, 32 bits: CSR write data.
REQ-011 SHALL have port o_busy, output, 1 bit: high when any slot is pending or the FSM is not IDLE.
REQ-012 SHALL have port o_wr_cnt, output, 16 bits: count of issued writes, saturating at 0xFFFF.

Function
REQ-013 SHALL keep one pending register per slot: slot0 UNC (0x34), slot1 INT (0x24), slot2 ADP (0x2C), slot3 LINK (0x14); each event pulse ORs into its pending bits.
REQ-014 SHALL mark LINK pending whenever i_link_sts differs from a shadow of the last written value; on issue, write the current i_link_sts and load the shadow with it.
REQ-015 SHALL run FSM IDLE -> HOLD (load counter with COALESCE_CYCLES) when any slot pending; HOLD decrements to 0 then -> ISSUE; with COALESCE_CYCLES=0, IDLE -> ISSUE directly.
REQ-016 SHALL issue at most one write per cycle in ISSUE, back-to-back while any slot is pending, then return to IDLE; there is no back-pressure.
REQ-017 SHALL choose the slot round-robin: the pointer resets to slot0, and after granting slot k the pointer becomes the next slot in ring order.
REQ-018 SHALL drive o_A_WDATA with the pending bits at their CSR bit positions and zeros elsewhere; INT bit 5 is always 0.
REQ-019 SHALL clear the granted slot's pending bits on issue, except that an event arriving in the issue cycle on that slot is retained as newly pending.
REQ-020 SHALL register all outputs; o_A_addr and o_A_WDATA are 0 when o_A_Valid is low.
REQ-021 SHALL make o_A_Valid rise exactly COALESCE_CYCLES+2 cycles after an event pulse received while IDLE with nothing pending.
REQ-022 SHALL not restart HOLD on events arriving during HOLD or ISSUE; those events are absorbed into the current burst.
REQ-023 SHALL increment o_wr_cnt by 1 per o_A_Valid cycle, saturating at 0xFFFF.

Reset
REQ-024 SHALL asynchronously clear, on i_rst_n low: all pending bits, the LINK shadow (0), the counter, the pointer (slot0), the FSM (IDLE), o_A_Valid/o_A_addr/o_A_WDATA (0), o_busy (0) and o_wr_cnt (0).
REQ-025 SHALL, if reset is asserted mid-burst, drop the remaining writes; after release a nonzero i_link_sts re-triggers a LINK write.

Configuration
REQ-026 SHALL compile in slot3 (LINK) only when macro UCIE_CTL_LINK_STS_EN is defined; without it, i_link_sts is ignored, address 0x14 is never written and the round-robin ring is slots 0..2.

Structure
REQ-027 SHALL take the CSR address constants (0x14, 0x24, 0x2C, 0x34), the FSM state enum and the slot enum from shared package ucie_ctl_csr_pkg.
REQ-028 SHALL implement slot selection in sub-module ucie_ctl_rr_arb, a 4-request round-robin arbiter with a one-hot grant.

Verification
REQ-029 SHALL cover: i_unc_err=6'h04 for 1 cycle, COALESCE_CYCLES=3 -> after 5 cycles, one strobe with addr 0x34, data 0x00000004; o_wr_cnt=1.
REQ-030 SHALL cover: i_int_err=8'hFF, then i_adp_err=2'b10 two cycles later -> strobes 0x24/0x000000DF then 0x2C/0x00000002 on consecutive cycles.
REQ-031 SHALL cover: i_unc_err=6'h01 pulsed in the same cycle as its 0x34 issue -> a second 0x34 write with data 0x00000001.
REQ-032 SHALL cover: i_link_sts changed 0 -> 0x00400003 with UCIE_CTL_LINK_STS_EN defined -> one 0x14 write of 0x00400003; with the macro undefined -> no write.
REQ-033 SHALL cover: reset asserted during HOLD with all slots pending -> outputs 0 immediately and no strobe after release, except LINK when i_link_sts is nonzero.
REQ-034 SHALL cover: o_wr_cnt preloaded to 0xFFFF via 65535 writes, then one further write -> o_wr_cnt stays 0xFFFF.

Source files
------------

// File: rtl/ucie_ctl_csr_pkg.sv
// Shared constants and enums for the UCIe controller CSR error collector:
// CSR addresses of the collected status registers, FSM states and slot ids.
package ucie_ctl_csr_pkg;

  localparam logic [7:0] CSR_ADDR_LINK = 8'h14;
  localparam logic [7:0] CSR_ADDR_INT  = 8'h24;
  localparam logic [7:0] CSR_ADDR_ADP  = 8'h2C;
  localparam logic [7:0] CSR_ADDR_UNC  = 8'h34;

  // INT status bit 5 is reserved and never reported
  localparam logic [7:0] INT_ERR_MASK = 8'hDF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SLOT_UNC  = 2'd0,
    SLOT_INT  = 2'd1,
    SLOT_ADP  = 2'd2,
    SLOT_LINK = 2'd3
  } slot_e;

  function automatic logic [7:0] slot_addr(input slot_e slot);
    logic [7:0] addr;
    case (slot)
      SLOT_UNC:  addr = CSR_ADDR_UNC;
      SLOT_INT:  addr = CSR_ADDR_INT;
      SLOT_ADP:  addr = CSR_ADDR_ADP;
      SLOT_LINK: addr = CSR_ADDR_LINK;
      default:   addr = 8'h00;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/ucie_ctl_rr_arb.sv
// Four-request round-robin arbiter with one-hot grant; the pointer moves to
// the slot after the granted one only when the grant is consumed (i_adv).
module ucie_ctl_rr_arb #(
  parameter int unsigned N_SLOTS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_adv,
  output logic [3:0] o_gnt
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] gidx_s;
  logic [1:0] idx_s;
  logic       found_s;

  // first requester at or after the pointer wins
  always_comb begin
    o_gnt   = 4'b0000;
    found_s = 1'b0;
    gidx_s  = ptr_q;
    idx_s   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx_s = ptr_q + 2'(i);
      if (!found_s && i_req[idx_s]) begin
        o_gnt[idx_s] = 1'b1;
        gidx_s       = idx_s;
        found_s      = 1'b1;
      end else begin
        o_gnt = o_gnt;
      end
    end
  end

  // wrap after the last slot of the ring in use
  always_comb begin
    if (i_adv && found_s) begin
      if (gidx_s == 2'(N_SLOTS - 1)) begin
        ptr_d = 2'd0;
      end else begin
        ptr_d = gidx_s + 2'd1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ucie_ctl_csr_err_collector.sv
// Collects error/status events into per-CSR pending slots and writes them out
// in coalesced round-robin bursts. Define UCIE_CTL_LINK_STS_EN to add the LINK slot.
module ucie_ctl_csr_err_collector
  import ucie_ctl_csr_pkg::*;
#(
  parameter int unsigned COALESCE_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [5:0]  i_unc_err,
  input  logic [7:0]  i_int_err,
  input  logic [1:0]  i_adp_err,
  input  logic [31:0] i_link_sts,
  output logic        o_A_Valid,
  output logic [7:0]  o_A_addr,
  output logic [31:0] o_A_WDATA,
  output logic        o_busy,
  output logic [15:0] o_wr_cnt
);

  localparam logic [3:0] HOLD_INIT = 4'(COALESCE_CYCLES);

`ifdef UCIE_CTL_LINK_STS_EN
  localparam int unsigned N_SLOTS = 4;
`else
  localparam int unsigned N_SLOTS = 3;
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  unc_pend_q, unc_pend_d;
  logic [7:0]  int_pend_q, int_pend_d;
  logic [1:0]  adp_pend_q, adp_pend_d;
  logic        valid_q, valid_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  logic [3:0]  req_s;
  logic [3:0]  gnt_s;
  logic [3:0]  gnt_use_s;
  logic        issue_s;
  logic        any_pend_q_s;
  logic        any_pend_d_s;
  slot_e       gslot_s;
  logic        link_pend_s;
  logic        link_pend_nxt_s;
  logic [31:0] link_wdata_s;

`ifdef UCIE_CTL_LINK_STS_EN
  logic        link_pend_q, link_pend_d;
  logic [31:0] shadow_q, shadow_d;

  // LINK is pending whenever the live word differs from the last one written
  always_comb begin
    if (gnt_use_s[3]) begin
      shadow_d = i_link_sts;
    end else begin
      shadow_d = shadow_q;
    end
    link_pend_d = (i_link_sts != shadow_d);
  end

  // LINK shadow and pending registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q    <= 32'd0;
      link_pend_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      link_pend_q <= link_pend_d;
    end
  end

  assign link_pend_s     = link_pend_q;
  assign link_pend_nxt_s = link_pend_d;
  assign link_wdata_s    = i_link_sts;
`else
  logic unused_link_s;
  assign unused_link_s   = ^i_link_sts;
  assign link_pend_s     = 1'b0;
  assign link_pend_nxt_s = 1'b0;
  assign link_wdata_s    = 32'd0;
`endif

  assign req_s = {link_pend_s, |adp_pend_q, |int_pend_q, |unc_pend_q};

  ucie_ctl_rr_arb #(
    .N_SLOTS (N_SLOTS)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (req_s),
    .i_adv   (issue_s),
    .o_gnt   (gnt_s)
  );

  // pending update: granted slot is cleared, same-cycle events are kept
  always_comb begin
    issue_s      = (state_q == ST_ISSUE) && (gnt_s != 4'b0000);
    gnt_use_s    = issue_s ? gnt_s : 4'b0000;
    any_pend_q_s = (|unc_pend_q) | (|int_pend_q) | (|adp_pend_q) | link_pend_s;
    unc_pend_d   = (gnt_use_s[0] ? 6'd0 : unc_pend_q) | i_unc_err;
    int_pend_d   = (gnt_use_s[1] ? 8'd0 : int_pend_q) | (i_int_err & INT_ERR_MASK);
    adp_pend_d   = (gnt_use_s[2] ? 2'd0 : adp_pend_q) | i_adp_err;
    any_pend_d_s = (|unc_pend_d) | (|int_pend_d) | (|adp_pend_d) | link_pend_nxt_s;
  end

  // IDLE -> HOLD -> ISSUE sequencing; HOLD leaves on the edge the count hits 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!any_pend_q_s) begin
          state_d = ST_IDLE;
        end else if (HOLD_INIT == 4'd0) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_ISSUE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_ISSUE: begin
        if (any_pend_d_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // write port image for the granted slot
  always_comb begin
    valid_d = issue_s;
    gslot_s = SLOT_UNC;
    wdata_d = 32'd0;
    case (gnt_use_s)
      4'b0001: begin gslot_s = SLOT_UNC;  wdata_d = {26'd0, unc_pend_q}; end
      4'b0010: begin gslot_s = SLOT_INT;  wdata_d = {24'd0, int_pend_q & INT_ERR_MASK}; end
      4'b0100: begin gslot_s = SLOT_ADP;  wdata_d = {30'd0, adp_pend_q}; end
      4'b1000: begin gslot_s = SLOT_LINK; wdata_d = link_wdata_s; end
      default: begin gslot_s = SLOT_UNC;  wdata_d = 32'd0; end
    endcase
    if (valid_d) begin
      addr_d = slot_addr(gslot_s);
    end else begin
      addr_d = 8'h00;
    end
    if (valid_d && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    busy_d = any_pend_d_s || (state_d != ST_IDLE);
  end

  // FSM, pending and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      unc_pend_q <= 6'd0;
      int_pend_q <= 8'd0;
      adp_pend_q <= 2'd0;
      valid_q    <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      wr_cnt_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      unc_pend_q <= unc_pend_d;
      int_pend_q <= int_pend_d;
      adp_pend_q <= adp_pend_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign o_A_Valid = valid_q;
  assign o_A_addr  = addr_q;
  assign o_A_WDATA = wdata_q;
  assign o_busy    = busy_q;
  assign o_wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_ucie_ctl_csr_err_collector.sv
// Scoreboard bench for ucie_ctl_csr_err_collector with COALESCE_CYCLES=3:
// directed stimulus pushes expected writes (addr, data, cycle); a monitor pops them.
module tb_ucie_ctl_csr_err_collector;

  localparam int LAT = 6;  // drive-cycle to strobe-sample offset for COALESCE_CYCLES=3

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [5:0]  i_unc_err;
  logic [7:0]  i_int_err;
  logic [1:0]  i_adp_err;
  logic [31:0] i_link_sts;
  logic        o_A_Valid;
  logic [7:0]  o_A_addr;
  logic [31:0] o_A_WDATA;
  logic        o_busy;
  logic [15:0] o_wr_cnt;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_wr = 16'd0;
  bit          sat_mode = 1'b0;
  bit          done = 1'b0;

  ucie_ctl_csr_err_collector #(
    .COALESCE_CYCLES (3)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_unc_err  (i_unc_err),
    .i_int_err  (i_int_err),
    .i_adp_err  (i_adp_err),
    .i_link_sts (i_link_sts),
    .o_A_Valid  (o_A_Valid),
    .o_A_addr   (o_A_addr),
    .o_A_WDATA  (o_A_WDATA),
    .o_busy     (o_busy),
    .o_wr_cnt   (o_wr_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] addr, input logic [31:0] data, input int at);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = at;
    sb_q.push_back(e);
    if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic drain(input string name);
    int k;
    cycles(10);
    k = 0;
    while ((sb_q.size() != 0 || o_busy) && k < 200) begin
      @(negedge i_clk);
      k++;
    end
    chk({name, "_left"}, sb_q.size(), 0);
    chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({name, "_wrcnt"}, {16'd0, o_wr_cnt}, {16'd0, exp_wr});
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, {31'd0, o_A_Valid}, 32'd0);
    chk({name, "_addr"},  {24'd0, o_A_addr}, 32'd0);
    chk({name, "_wdata"}, o_A_WDATA, 32'd0);
    chk({name, "_busy"},  {31'd0, o_busy}, 32'd0);
    chk({name, "_wrcnt"}, {16'd0, o_wr_cnt}, 32'd0);
  endtask

  initial begin
    fork
      // monitor: compares every strobe against the scoreboard
      begin
        exp_t e;
        while (!done) begin
          @(negedge i_clk);
          if (i_rst_n && o_A_Valid) begin
            if (sat_mode) begin
              chk("sat_addr", {24'd0, o_A_addr}, 32'h34);
              chk("sat_data", o_A_WDATA, 32'h1);
            end else if (sb_q.size() == 0) begin
              chk("unexpected_strobe_addr", {24'd0, o_A_addr}, 32'hFFFF_FFFF);
            end else begin
              e = sb_q.pop_front();
              chk("strobe_addr", {24'd0, o_A_addr}, {24'd0, e.addr});
              chk("strobe_data", o_A_WDATA, e.data);
              chk("strobe_cycle", cyc, e.cyc);
            end
          end else if (!o_A_Valid && (o_A_addr != 8'h00 || o_A_WDATA != 32'd0)) begin
            chk("idle_bus", {24'd0, o_A_addr} | o_A_WDATA, 32'd0);
          end
        end
      end
      // stimulus
      begin
        int c;
        int k;
        i_rst_n = 1'b0;
        i_unc_err = 6'd0; i_int_err = 8'd0; i_adp_err = 2'd0; i_link_sts = 32'd0;
        cycles(3);
        chk_zero("reset");
        i_rst_n = 1'b1;
        cycles(2);

        // single UNC event
        c = cyc;
        i_unc_err = 6'h04;
        push(8'h34, 32'h0000_0004, c + LAT);
        @(negedge i_clk) i_unc_err = 6'd0;
        drain("unc_single");

        // INT then ADP two cycles later, back-to-back strobes, bit 5 dropped
        c = cyc;
        i_int_err = 8'hFF;
        push(8'h24, 32'h0000_00DF, c + LAT);
        push(8'h2C, 32'h0000_0002, c + LAT + 1);
        @(negedge i_clk) i_int_err = 8'd0;
        @(negedge i_clk) i_adp_err = 2'b10;
        @(negedge i_clk) i_adp_err = 2'b00;
        drain("int_adp");

        // UNC event in its own issue cycle is retained as a second write
        c = cyc;
        i_unc_err = 6'h04;
        push(8'h34, 32'h0000_0004, c + LAT);
        push(8'h34, 32'h0000_0001, c + LAT + 1);
        @(negedge i_clk) i_unc_err = 6'd0;
        cycles(4);
        i_unc_err = 6'h01;
        @(negedge i_clk) i_unc_err = 6'd0;
        drain("unc_retain");

        // link status change
        c = cyc;
        i_link_sts = 32'h0040_0003;
`ifdef UCIE_CTL_LINK_STS_EN
        push(8'h14, 32'h0040_0003, c + LAT);
`endif
        drain("link");

        // reset during HOLD with every slot pending
        i_unc_err = 6'h3F; i_int_err = 8'hFF; i_adp_err = 2'b11; i_link_sts = 32'h0000_0101;
        @(negedge i_clk);
        i_unc_err = 6'd0; i_int_err = 8'd0; i_adp_err = 2'd0;
        @(negedge i_clk);
        chk("hold_busy", {31'd0, o_busy}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        exp_wr = 16'd0;
        cycles(2);
        c = cyc;
        i_rst_n = 1'b1;
`ifdef UCIE_CTL_LINK_STS_EN
        push(8'h14, 32'h0000_0101, c + LAT);
`endif
        drain("post_reset");

        // saturation of the write counter under continuous UNC events
        sat_mode = 1'b1;
        i_unc_err = 6'h01;
        k = 0;
        while (o_wr_cnt != 16'hFFFF && k < 70000) begin
          @(negedge i_clk);
          k++;
        end
        chk("sat_reach", {16'd0, o_wr_cnt}, 32'h0000_FFFF);
        cycles(8);
        chk("sat_still_issuing", {31'd0, o_A_Valid}, 32'd1);
        chk("sat_hold", {16'd0, o_wr_cnt}, 32'h0000_FFFF);
        i_unc_err = 6'd0;
        cycles(10);
        sat_mode = 1'b0;
        chk("sat_idle_busy", {31'd0, o_busy}, 32'd0);
        chk("sat_final", {16'd0, o_wr_cnt}, 32'h0000_FFFF);

        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
